// File: rtl/and_gate_share_arb.sv
// and_gate_share_arb: round-robin arbiter sharing one registered AND datapath among NUM_REQ requesters
// Optional feature macro AND_ARB_GRANT_CNT_EN adds a 16-bit saturating GRANT_CNT output.
module and_gate_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 1,
  parameter int ID_W    = 2
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic [NUM_REQ-1:0]       REQ_VALID,
  output logic [NUM_REQ-1:0]       REQ_READY,
  input  logic [NUM_REQ*WIDTH-1:0] REQ_A,
  input  logic [NUM_REQ*WIDTH-1:0] REQ_B,
  output logic                     RSP_VALID,
  input  logic                     RSP_READY,
  output logic [WIDTH-1:0]         RSP_Y,
  output logic [ID_W-1:0]          RSP_ID
`ifdef AND_ARB_GRANT_CNT_EN
  ,
  output logic [15:0]              GRANT_CNT
`endif
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t r_state, w_state_nxt;
  logic [ID_W-1:0] r_ptr, r_id, w_g, w_ptr_nxt;
  logic [WIDTH-1:0] r_y, w_y;
  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0] w_rot;
  logic w_found, w_accept_ok, w_accept;
  int w_gi;
  // Rotate requests so the search always starts at bit 0 = requester PTR
  assign w_dbl = {REQ_VALID, REQ_VALID} >> r_ptr;
  assign w_rot = w_dbl[NUM_REQ-1:0];
  // Find the first valid requester at or after PTR, wrapping around
  always_comb begin
    w_found = 1'b0;
    w_gi = 0;
    for (int k = 0; k < NUM_REQ; k++)
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_gi = (k + int'(r_ptr)) % NUM_REQ;
      end
  end
  assign w_g         = ID_W'(w_gi);
  assign w_ptr_nxt   = ID_W'((w_gi + 1) % NUM_REQ);
  assign w_accept_ok = RESET_N && (r_state == IDLE || RSP_READY);
  assign w_accept    = w_accept_ok && w_found;
  assign REQ_READY   = w_accept ? (NUM_REQ'(1) << w_gi) : '0;
  assign w_y         = WIDTH'(REQ_A >> (w_gi * WIDTH)) & WIDTH'(REQ_B >> (w_gi * WIDTH));
  // Next state: accept fills the register, a drain with no accept empties it
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = w_accept ? HOLD : (r_state == HOLD && RSP_READY) ? IDLE : r_state;
  end
  // State register
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) r_state <= IDLE;
    else r_state <= w_state_nxt;
  // Result register and round-robin pointer update on accept
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      r_y   <= '0;
      r_id  <= '0;
      r_ptr <= '0;
    end else if (w_accept) begin
      r_y   <= w_y;
      r_id  <= w_g;
      r_ptr <= w_ptr_nxt;
    end
  assign RSP_VALID = (r_state == HOLD);
  assign RSP_Y     = r_y;
  assign RSP_ID    = r_id;
`ifdef AND_ARB_GRANT_CNT_EN
  logic [15:0] r_cnt;
  // Saturating count of accepted requests
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) r_cnt <= '0;
    else if (w_accept && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
  assign GRANT_CNT = r_cnt;
`else
`endif
endmodule

// File: tb/tb_and_gate_share_arb.sv
// tb_and_gate_share_arb: directed self-checking bench for and_gate_share_arb
module tb_and_gate_share_arb;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] v, rdy;
  logic [15:0] a, b;
  logic rsp_valid, rsp_ready;
  logic [3:0] y;
  logic [1:0] id;
  logic [2:0] v3, rdy3;
  logic [11:0] a3, b3;
  logic rsp_valid3, rsp_ready3;
  logic [3:0] y3;
  logic [1:0] id3;
`ifdef AND_ARB_GRANT_CNT_EN
  logic [15:0] cnt, cnt3;
`endif
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  and_gate_share_arb #(.NUM_REQ(4), .WIDTH(4), .ID_W(2)) u_dut (
    .CLK(clk), .RESET_N(rst_n), .REQ_VALID(v), .REQ_READY(rdy), .REQ_A(a), .REQ_B(b),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_Y(y), .RSP_ID(id)
`ifdef AND_ARB_GRANT_CNT_EN
    , .GRANT_CNT(cnt)
`endif
  );

  and_gate_share_arb #(.NUM_REQ(3), .WIDTH(4), .ID_W(2)) u_dut3 (
    .CLK(clk), .RESET_N(rst_n), .REQ_VALID(v3), .REQ_READY(rdy3), .REQ_A(a3), .REQ_B(b3),
    .RSP_VALID(rsp_valid3), .RSP_READY(rsp_ready3), .RSP_Y(y3), .RSP_ID(id3)
`ifdef AND_ARB_GRANT_CNT_EN
    , .GRANT_CNT(cnt3)
`endif
  );

  task automatic test_reset;
    rst_n = 1'b0;
    v = 4'b1111;
    #3;
    n_tests++; if (rdy !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got=%b exp=0000", rdy); end
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", rsp_valid); end
    n_tests++; if (y !== 4'h0 || id !== 2'd0) begin n_fail++; $display("FAIL reset_data got y=%h id=%0d exp y=0 id=0", y, id); end
`ifdef AND_ARB_GRANT_CNT_EN
    n_tests++; if (cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
`endif
    @(negedge clk);
    v = 4'b0000;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (rsp_valid !== 1'b0 || y !== 4'h0 || id !== 2'd0 || rdy !== 4'b0000) begin
      n_fail++; $display("FAIL idle_release got valid=%b y=%h id=%0d rdy=%b exp 0/0/0/0000", rsp_valid, y, id, rdy);
    end
  endtask

  task automatic test_single;
    @(negedge clk);
    a = 16'h0C00;
    b = 16'h0A00;
    v = 4'b0100;
    rsp_ready = 1'b1;
    #1;
    n_tests++; if (rdy !== 4'b0100) begin n_fail++; $display("FAIL single_ready got=%b exp=0100", rdy); end
    @(posedge clk); #1;
    n_tests++; if (rsp_valid !== 1'b1 || y !== 4'b1000 || id !== 2'd2) begin
      n_fail++; $display("FAIL single_rsp got valid=%b y=%b id=%0d exp 1/1000/2", rsp_valid, y, id);
    end
    @(negedge clk);
    v = 4'b0000;
    @(posedge clk); #1;
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain got=%b exp=0", rsp_valid); end
    n_tests++; if (y !== 4'b1000 || id !== 2'd2) begin n_fail++; $display("FAIL single_keep got y=%b id=%0d exp 1000/2", y, id); end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_y [4];
    exp_y[0] = 4'h5; exp_y[1] = 4'h0; exp_y[2] = 4'h3; exp_y[3] = 4'h4;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    a = 16'hC3A5;
    b = 16'h6F0F;
    v = 4'b1111;
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      n_tests++; if (rsp_valid !== 1'b1 || id !== 2'(i % 4) || y !== exp_y[i % 4]) begin
        n_fail++; $display("FAIL rr_step%0d got valid=%b id=%0d y=%h exp 1/%0d/%h", i, rsp_valid, id, y, i % 4, exp_y[i % 4]);
      end
    end
`ifdef AND_ARB_GRANT_CNT_EN
    n_tests++; if (cnt !== 16'd8) begin n_fail++; $display("FAIL rr_cnt got=%0d exp=8", cnt); end
`endif
    @(negedge clk);
    v = 4'b0000;
    @(posedge clk); #1;
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rr_drain got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_back_pressure;
    @(negedge clk);
    b = 16'hFFFF;
    v = 4'b0010;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (rsp_valid !== 1'b1 || id !== 2'd1 || y !== 4'hA) begin
      n_fail++; $display("FAIL bp_load got valid=%b id=%0d y=%h exp 1/1/a", rsp_valid, id, y);
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    v = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (rdy !== 4'b0000) begin n_fail++; $display("FAIL bp_ready%0d got=%b exp=0000", i, rdy); end
      @(posedge clk); #1;
      n_tests++; if (rsp_valid !== 1'b1 || id !== 2'd1 || y !== 4'hA) begin
        n_fail++; $display("FAIL bp_hold%0d got valid=%b id=%0d y=%h exp 1/1/a", i, rsp_valid, id, y);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    n_tests++; if (rdy !== 4'b0100) begin n_fail++; $display("FAIL bp_release_ready got=%b exp=0100", rdy); end
    @(posedge clk); #1;
    n_tests++; if (rsp_valid !== 1'b1 || id !== 2'd2 || y !== 4'h3) begin
      n_fail++; $display("FAIL bp_next got valid=%b id=%0d y=%h exp 1/2/3", rsp_valid, id, y);
    end
    @(negedge clk);
    v = 4'b0000;
    @(posedge clk); #1;
  endtask

  task automatic test_wrap;
    @(negedge clk);
    a3 = 12'hFFF;
    b3 = 12'h963;
    rsp_ready3 = 1'b1;
    v3 = 3'b100;
    #1;
    n_tests++; if (rdy3 !== 3'b100) begin n_fail++; $display("FAIL wrap_ready2 got=%b exp=100", rdy3); end
    @(posedge clk); #1;
    n_tests++; if (id3 !== 2'd2 || y3 !== 4'h9) begin n_fail++; $display("FAIL wrap_g2 got id=%0d y=%h exp 2/9", id3, y3); end
    @(negedge clk);
    v3 = 3'b011;
    #1;
    n_tests++; if (rdy3 !== 3'b001) begin n_fail++; $display("FAIL wrap_ready0 got=%b exp=001", rdy3); end
    @(posedge clk); #1;
    n_tests++; if (id3 !== 2'd0 || y3 !== 4'h3) begin n_fail++; $display("FAIL wrap_g0 got id=%0d y=%h exp 0/3", id3, y3); end
    @(negedge clk); #1;
    n_tests++; if (rdy3 !== 3'b010) begin n_fail++; $display("FAIL wrap_ready1 got=%b exp=010", rdy3); end
    @(posedge clk); #1;
    n_tests++; if (id3 !== 2'd1 || y3 !== 4'h6 || rsp_valid3 !== 1'b1) begin
      n_fail++; $display("FAIL wrap_g1 got id=%0d y=%h valid=%b exp 1/6/1", id3, y3, rsp_valid3);
    end
    @(negedge clk);
    v3 = 3'b000;
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    v = 4'b1000;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (rsp_valid !== 1'b1 || id !== 2'd3) begin n_fail++; $display("FAIL mid_load got valid=%b id=%0d exp 1/3", rsp_valid, id); end
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++; if (rsp_valid !== 1'b0 || id !== 2'd0) begin
      n_fail++; $display("FAIL mid_async got valid=%b id=%0d exp 0/0", rsp_valid, id);
    end
    @(negedge clk);
    v = 4'b1010;
    rst_n = 1'b1;
    #1;
    n_tests++; if (rdy !== 4'b0010) begin n_fail++; $display("FAIL mid_ready got=%b exp=0010", rdy); end
    @(posedge clk); #1;
    n_tests++; if (rsp_valid !== 1'b1 || id !== 2'd1) begin n_fail++; $display("FAIL mid_first got valid=%b id=%0d exp 1/1", rsp_valid, id); end
    @(negedge clk);
    v = 4'b0000;
  endtask

  initial begin
    rst_n = 1'b0;
    v = '0; a = '0; b = '0; rsp_ready = 1'b0;
    v3 = '0; a3 = '0; b3 = '0; rsp_ready3 = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/and_gate_share_arb.md
Name: and_gate_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one registered N-bit AND datapath among NUM_REQ requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- The block grants one requester per cycle, computes Y = A & B into an output register, and presents the result with the winner's ID on a valid/ready response port.
- Sits between requester-side logic and a single downstream result consumer.

Parameters:
- NUM_REQ, 4, number of requesters (1..16, need not be a power of 2).
- WIDTH, 1, operand/result bit width.
- ID_W, 2, width of RSP_ID; must be >= clog2(NUM_REQ), and 1 when NUM_REQ=1.

Ports:
- CLK  input  1  clock, rising edge.
- RESET_N  input  1  asynchronous active-low reset.
- REQ_VALID  input  NUM_REQ  per-requester operand valid.
- REQ_READY  output  NUM_REQ  per-requester accept; one-hot or zero.
- REQ_A  input  NUM_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- REQ_B  input  NUM_REQ*WIDTH  operand B; same packing as REQ_A.
- RSP_VALID  output  1  result valid.
- RSP_READY  input  1  consumer accepts result.
- RSP_Y  output  WIDTH  registered A & B of the granted requester.
- RSP_ID  output  ID_W  index of the requester that produced RSP_Y.

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low on RESET_N; assertion takes effect immediately, with no clock needed.
- Reset values: RSP_VALID=0, RSP_Y=0, RSP_ID=0, round-robin pointer PTR=0, state IDLE. REQ_READY=0 while RESET_N=0.
- States:
  - IDLE: output register empty.
  - HOLD: output register full, RSP_VALID=1.
- accept_ok = (state==IDLE) | (state==HOLD & RSP_READY).
- Arbitration (combinational, every cycle):
  - Winner g = first i with REQ_VALID[i]=1, searching PTR, PTR+1, ..., NUM_REQ-1, 0, ..., PTR-1.
  - REQ_READY[g]=1 only when accept_ok and a winner exists; all other REQ_READY bits are 0.
- Accept (rising edge with REQ_VALID[g] & REQ_READY[g]):
  - RSP_Y <= REQ_A[g] & REQ_B[g]; RSP_ID <= g; RSP_VALID <= 1; state <= HOLD.
  - PTR <= g+1, wrapping from NUM_REQ-1 to 0.
- Latency: result visible the cycle after acceptance.
- Throughput: 1 result/cycle when RSP_READY is held high (accept while draining in HOLD).
- Drain with no new accept (HOLD & RSP_READY & no winner): RSP_VALID <= 0, state <= IDLE. RSP_Y/RSP_ID keep their last value.
- Stall (HOLD & !RSP_READY):
  - RSP_Y, RSP_ID, RSP_VALID stay stable; REQ_READY all 0.
  - PTR unchanged.
- Request rules:
  - Requesters must hold REQ_A/REQ_B stable while REQ_VALID is high and not yet accepted.
  - A requester may drop REQ_VALID before acceptance; arbitration re-evaluates every cycle with no lock.
- Fairness: with all requesters continuously valid and RSP_READY=1, grants cycle 0,1,...,NUM_REQ-1,0,... No requester waits more than NUM_REQ-1 accepts.
- NUM_REQ=1: PTR is constant 0 and RSP_ID=0 always.
- Reset mid-HOLD: the held result is discarded and RSP_VALID drops asynchronously; the first grant after release goes to the lowest valid index, since PTR=0.
- No combinational path from RSP_READY to RSP_VALID/RSP_Y. A path from RSP_READY to REQ_READY is permitted.

Optional Feature:
- Macro: AND_ARB_GRANT_CNT_EN.
- Defined:
  - Adds output port GRANT_CNT (16 bits): a saturating count of accepted requests.
  - Increments by 1 on each accept edge and holds at 16'hFFFF.
  - Reset value 0 (asynchronous with RESET_N).
- Undefined: the port and counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset/idle: RESET_N=0 with REQ_VALID=4'b1111 -> REQ_READY=0, RSP_VALID=0, RSP_Y=0, RSP_ID=0. Release with all requests idle -> outputs unchanged.
- Single request, WIDTH=4: REQ_VALID=4'b0100, A2=4'b1100, B2=4'b1010, RSP_READY=1 -> REQ_READY=4'b0100 in the same cycle; next cycle RSP_VALID=1, RSP_Y=4'b1000, RSP_ID=2; then RSP_VALID=0.
- Round-robin: REQ_VALID=4'b1111 held, RSP_READY=1 for 8 cycles -> RSP_ID sequence 0,1,2,3,0,1,2,3 on consecutive cycles; with the macro defined, GRANT_CNT=8.
- Back-pressure: RSP_VALID=1 with RSP_ID=1, RSP_READY=0 for 3 cycles, REQ_VALID=4'b1111 -> REQ_READY=0, RSP_Y/RSP_ID stable. RSP_READY=1 -> REQ_READY=4'b0100, next RSP_ID=2.
- Pointer wrap, NUM_REQ=3: grant requester 2, then REQ_VALID=3'b011 -> next grant requester 0, then requester 1.
- Reset mid-operation: assert RESET_N=0 while RSP_VALID=1, RSP_ID=3 -> RSP_VALID=0 immediately, with no clock edge. Release with REQ_VALID=4'b1010 -> first grant ID=1.
